// File: rtl/stopwatch_ctrl.sv
// Run-control sequencer for the 00.00-99.99 stopwatch.
// Five-state FSM drives the counter chain's enable and clear, captures lap
// values and holds them frozen on the display for LAP_HOLD_TICKS ticks.
module stopwatch_ctrl #(
   parameter int unsigned LAP_HOLD_TICKS = 300
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        tick,
   input  logic        start_p,
   input  logic        stop_p,
   input  logic        lap_p,
   input  logic        clr_p,
   input  logic        sat,
   input  logic [15:0] live_bcd,
   output logic        run_en,
   output logic        cnt_clr,
   output logic [15:0] disp_bcd,
   output logic        lap_active,
   output logic [3:0]  lap_count,
   output logic [2:0]  state
);

   localparam int unsigned HoldW = $clog2(LAP_HOLD_TICKS + 1);
   localparam logic [HoldW-1:0] HoldLast = HoldW'(LAP_HOLD_TICKS - 1);
   localparam logic [HoldW-1:0] HoldOne  = HoldW'(1);

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StRun   = 3'd1,
      StLap   = 3'd2,
      StPause = 3'd3,
      StDone  = 3'd4
   } state_e;

   state_e           state_q;
   logic             run_en_q;
   logic             lap_active_q;
   logic             cnt_clr_q;
   logic [15:0]      lap_reg_q;
   logic [3:0]       lap_count_q;
   logic [HoldW-1:0] hold_q;

   // State transitions with registered outputs; each branch picks the single
   // highest-priority input that is meaningful in the current state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         run_en_q     <= 1'b0;
         lap_active_q <= 1'b0;
         cnt_clr_q    <= 1'b0;
         lap_reg_q    <= '0;
         lap_count_q  <= '0;
         hold_q       <= '0;
      end else begin
         cnt_clr_q <= 1'b0;
         case (state_q)
            StIdle: begin
               if (clr_p) begin
                  cnt_clr_q   <= 1'b1;
                  lap_count_q <= '0;
               end else if (start_p) begin
                  state_q  <= StRun;
                  run_en_q <= 1'b1;
               end
            end
            StRun: begin
               if (sat) begin
                  state_q  <= StDone;
                  run_en_q <= 1'b0;
               end else if (stop_p) begin
                  state_q  <= StPause;
                  run_en_q <= 1'b0;
               end else if (lap_p) begin
                  state_q      <= StLap;
                  lap_active_q <= 1'b1;
                  lap_reg_q    <= live_bcd;
                  hold_q       <= '0;
                  if (lap_count_q != 4'd15) lap_count_q <= lap_count_q + 4'd1;
               end
            end
            StLap: begin
               if (sat) begin
                  state_q      <= StDone;
                  run_en_q     <= 1'b0;
                  lap_active_q <= 1'b0;
                  hold_q       <= '0;
               end else if (stop_p) begin
                  state_q      <= StPause;
                  run_en_q     <= 1'b0;
                  lap_active_q <= 1'b0;
                  hold_q       <= '0;
               end else if (lap_p) begin
                  // Re-latch restarts the freeze even if a tick lands this cycle
                  lap_reg_q <= live_bcd;
                  hold_q    <= '0;
                  if (lap_count_q != 4'd15) lap_count_q <= lap_count_q + 4'd1;
               end else if (tick) begin
                  if (hold_q == HoldLast) begin
                     state_q      <= StRun;
                     lap_active_q <= 1'b0;
                     hold_q       <= '0;
                  end else begin
                     hold_q <= hold_q + HoldOne;
                  end
               end
            end
            StPause: begin
               if (clr_p) begin
                  state_q     <= StIdle;
                  cnt_clr_q   <= 1'b1;
                  lap_count_q <= '0;
               end else if (start_p) begin
                  state_q  <= StRun;
                  run_en_q <= 1'b1;
               end
            end
            StDone: begin
               if (clr_p) begin
                  state_q     <= StIdle;
                  cnt_clr_q   <= 1'b1;
                  lap_count_q <= '0;
               end
            end
            default: begin
               // Unused encodings recover to a quiet idle
               state_q      <= StIdle;
               run_en_q     <= 1'b0;
               lap_active_q <= 1'b0;
               hold_q       <= '0;
            end
         endcase
      end
   end

   // Display mux: frozen lap value while in LAP, live digits otherwise
   always_comb begin
      disp_bcd = lap_active_q ? lap_reg_q : live_bcd;
   end

   assign run_en     = run_en_q;
   assign cnt_clr    = cnt_clr_q;
   assign lap_active = lap_active_q;
   assign lap_count  = lap_count_q;
   assign state      = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed, table-driven bench for stopwatch_ctrl with LAP_HOLD_TICKS=3.
module tb_stopwatch_ctrl;

   logic        clk;
   logic        rst_n;
   logic        tick;
   logic        start_p;
   logic        stop_p;
   logic        lap_p;
   logic        clr_p;
   logic        sat;
   logic [15:0] live_bcd;
   logic        run_en;
   logic        cnt_clr;
   logic [15:0] disp_bcd;
   logic        lap_active;
   logic [3:0]  lap_count;
   logic [2:0]  state;

   int checks;
   int failures;

   stopwatch_ctrl #(
      .LAP_HOLD_TICKS(3)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .tick      (tick),
      .start_p   (start_p),
      .stop_p    (stop_p),
      .lap_p     (lap_p),
      .clr_p     (clr_p),
      .sat       (sat),
      .live_bcd  (live_bcd),
      .run_en    (run_en),
      .cnt_clr   (cnt_clr),
      .disp_bcd  (disp_bcd),
      .lap_active(lap_active),
      .lap_count (lap_count),
      .state     (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [5:0]  in;    // {start, stop, lap, clr, sat, tick}
      logic [15:0] live;
      logic [2:0]  st;
      logic        run;
      logic        cc;
      logic        la;
      logic [3:0]  cnt;
      logic [15:0] disp;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input string n, input logic [5:0] in, input logic [15:0] live,
                               input logic [2:0] st, input logic run, input logic cc,
                               input logic la, input logic [3:0] cnt,
                               input logic [15:0] disp);
      vec_t v;
      v.name = n; v.in = in; v.live = live; v.st = st; v.run = run; v.cc = cc;
      v.la = la; v.cnt = cnt; v.disp = disp;
      return v;
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_all(input string name, input logic [2:0] st, input logic run,
                          input logic cc, input logic la, input logic [3:0] cnt,
                          input logic [15:0] disp);
      chk({name, ".state"}, {13'd0, state}, {13'd0, st});
      chk({name, ".run_en"}, {15'd0, run_en}, {15'd0, run});
      chk({name, ".cnt_clr"}, {15'd0, cnt_clr}, {15'd0, cc});
      chk({name, ".lap_active"}, {15'd0, lap_active}, {15'd0, la});
      chk({name, ".lap_count"}, {12'd0, lap_count}, {12'd0, cnt});
      chk({name, ".disp_bcd"}, disp_bcd, disp);
   endtask

   // Drive one cycle of inputs (called at a negedge), clock it, return at next negedge
   task automatic step(input logic [5:0] in, input logic [15:0] live);
      {start_p, stop_p, lap_p, clr_p, sat, tick} = in;
      live_bcd = live;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      int c;
      bit found;
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      {start_p, stop_p, lap_p, clr_p, sat, tick} = 6'b0;
      live_bcd = 16'h1111;

      vecs.push_back(mk("start",          6'b100000, 16'h0000, 3'd1, 1, 0, 0, 4'd0, 16'h0000));
      vecs.push_back(mk("stop",           6'b010000, 16'h0001, 3'd3, 0, 0, 0, 4'd0, 16'h0001));
      vecs.push_back(mk("restart",        6'b100000, 16'h0002, 3'd1, 1, 0, 0, 4'd0, 16'h0002));
      vecs.push_back(mk("lap1",           6'b001000, 16'h0123, 3'd2, 1, 0, 1, 4'd1, 16'h0123));
      vecs.push_back(mk("hold_t1",        6'b000001, 16'h0124, 3'd2, 1, 0, 1, 4'd1, 16'h0123));
      vecs.push_back(mk("hold_t2",        6'b000001, 16'h0125, 3'd2, 1, 0, 1, 4'd1, 16'h0123));
      vecs.push_back(mk("hold_exp",       6'b000001, 16'h0126, 3'd1, 1, 0, 0, 4'd1, 16'h0126));
      vecs.push_back(mk("lap2",           6'b001000, 16'h0200, 3'd2, 1, 0, 1, 4'd2, 16'h0200));
      vecs.push_back(mk("lap2_t1",        6'b000001, 16'h0201, 3'd2, 1, 0, 1, 4'd2, 16'h0200));
      vecs.push_back(mk("lap2_t2",        6'b000001, 16'h0202, 3'd2, 1, 0, 1, 4'd2, 16'h0200));
      vecs.push_back(mk("relap_tick",     6'b001001, 16'h0456, 3'd2, 1, 0, 1, 4'd3, 16'h0456));
      vecs.push_back(mk("relap_t1",       6'b000001, 16'h0457, 3'd2, 1, 0, 1, 4'd3, 16'h0456));
      vecs.push_back(mk("relap_t2",       6'b000001, 16'h0458, 3'd2, 1, 0, 1, 4'd3, 16'h0456));
      vecs.push_back(mk("relap_idle",     6'b000000, 16'h0459, 3'd2, 1, 0, 1, 4'd3, 16'h0456));
      vecs.push_back(mk("relap_exp",      6'b000001, 16'h0460, 3'd1, 1, 0, 0, 4'd3, 16'h0460));
      vecs.push_back(mk("stop_lap",       6'b011000, 16'h0500, 3'd3, 0, 0, 0, 4'd3, 16'h0500));
      vecs.push_back(mk("pause_lap",      6'b001000, 16'h0501, 3'd3, 0, 0, 0, 4'd3, 16'h0501));
      vecs.push_back(mk("resume",         6'b100000, 16'h0502, 3'd1, 1, 0, 0, 4'd3, 16'h0502));
      vecs.push_back(mk("run_clr",        6'b000100, 16'h0503, 3'd1, 1, 0, 0, 4'd3, 16'h0503));
      vecs.push_back(mk("stop2",          6'b010000, 16'h0504, 3'd3, 0, 0, 0, 4'd3, 16'h0504));
      vecs.push_back(mk("pause_clr",      6'b000100, 16'h0505, 3'd0, 0, 1, 0, 4'd0, 16'h0505));
      vecs.push_back(mk("clr_pulse_end",  6'b000000, 16'h0000, 3'd0, 0, 0, 0, 4'd0, 16'h0000));
      vecs.push_back(mk("idle_clr",       6'b000100, 16'h0000, 3'd0, 0, 1, 0, 4'd0, 16'h0000));
      vecs.push_back(mk("start3",         6'b100000, 16'h0001, 3'd1, 1, 0, 0, 4'd0, 16'h0001));
      vecs.push_back(mk("lap3",           6'b001000, 16'h0777, 3'd2, 1, 0, 1, 4'd1, 16'h0777));
      vecs.push_back(mk("lap_sat",        6'b000010, 16'h9999, 3'd4, 0, 0, 0, 4'd1, 16'h9999));
      vecs.push_back(mk("done_start",     6'b100000, 16'h9999, 3'd4, 0, 0, 0, 4'd1, 16'h9999));
      vecs.push_back(mk("done_lapstop",   6'b011000, 16'h9999, 3'd4, 0, 0, 0, 4'd1, 16'h9999));
      vecs.push_back(mk("done_clr_sat",   6'b000110, 16'h9999, 3'd0, 0, 1, 0, 4'd0, 16'h9999));
      vecs.push_back(mk("start4",         6'b100000, 16'h0000, 3'd1, 1, 0, 0, 4'd0, 16'h0000));
      vecs.push_back(mk("run_sat_stop",   6'b010010, 16'h9999, 3'd4, 0, 0, 0, 4'd0, 16'h9999));
      vecs.push_back(mk("clr4",           6'b000100, 16'h0000, 3'd0, 0, 1, 0, 4'd0, 16'h0000));
      vecs.push_back(mk("idle_start_lap", 6'b101000, 16'h0010, 3'd1, 1, 0, 0, 4'd0, 16'h0010));
      vecs.push_back(mk("run_clr_lap",    6'b001100, 16'h0011, 3'd2, 1, 0, 1, 4'd1, 16'h0011));
      vecs.push_back(mk("lap_start_tick", 6'b100001, 16'h0012, 3'd2, 1, 0, 1, 4'd1, 16'h0011));

      // Reset state
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk_all("reset", 3'd0, 0, 0, 0, 4'd0, 16'h1111);

      foreach (vecs[i]) begin
         step(vecs[i].in, vecs[i].live);
         chk_all(vecs[i].name, vecs[i].st, vecs[i].run, vecs[i].cc, vecs[i].la, vecs[i].cnt,
                 vecs[i].disp);
      end

      // lap_count saturates at 15 (starts from 1 in LAP)
      for (int i = 0; i < 16; i++) begin
         step(6'b001000, 16'(i));
         chk("lap_sat_cnt", {12'd0, lap_count}, {12'd0, ((i + 2) > 15) ? 4'd15 : 4'(i + 2)});
         chk("lap_sat_disp", disp_bcd, 16'(i));
      end
      step(6'b010000, 16'h0000);
      chk_all("sat_stop", 3'd3, 0, 0, 0, 4'd15, 16'h0000);
      step(6'b000100, 16'h0000);
      chk_all("sat_clr", 3'd0, 0, 1, 0, 4'd0, 16'h0000);

      // Freeze length with a tick every 10 cycles
      step(6'b100000, 16'h0000);
      step(6'b001000, 16'h0321);
      chk_all("tlap", 3'd2, 1, 0, 1, 4'd1, 16'h0321);
      found = 0;
      c = 0;
      for (int k = 1; k <= 100; k++) begin
         step({5'b00000, (k % 10) == 0}, 16'(16'h1000 + k));
         if (!lap_active) begin
            found = 1;
            c = k;
            break;
         end
         chk("tfreeze_disp", disp_bcd, 16'h0321);
      end
      if (!found) $display("FAIL tfreeze_timeout: lap_active still 1 after 100 cycles");
      chk("tfreeze_len", 16'(c), 16'd30);
      chk_all("tfreeze_end", 3'd1, 1, 0, 0, 4'd1, 16'(16'h1000 + c));

      // Asynchronous reset mid-RUN, away from any clock edge
      #1 rst_n = 1'b0;
      #1;
      chk_all("async_rst", 3'd0, 0, 0, 0, 4'd0, live_bcd);
      rst_n = 1'b1;
      @(negedge clk);
      chk_all("post_rst", 3'd0, 0, 0, 0, 4'd0, live_bcd);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
